// File: rtl/spi_match_pkg.sv
// Shared opcodes and FSM state encoding for the SPI pattern-match engine.
package spi_match_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READ_ADDR   = 3'd1,
    READ_BURST  = 3'd2,
    WRITE_ADDR  = 3'd3,
    WRITE_DATA  = 3'd4,
    STREAM      = 3'd5
  } state_t;

  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_CLEAR  = 8'h04;
  localparam logic [7:0] OP_STREAM = 8'h80;

endpackage

// File: rtl/spi_match_cam.sv
// Parallel compare of a stream word against every char entry, OR-reducing
// the masks of all matching entries (no priority between entries).
module spi_match_cam
  import spi_match_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ENTRIES = 8
) (
  input  logic [ENTRIES-1:0][DW-1:0] char_vec,
  input  logic [ENTRIES-1:0][DW-1:0] mask_vec,
  input  logic [DW-1:0]              mosi,
  output logic [DW-1:0]              match_mask,
  output logic                       any_match
);

  // Accumulate masks of every entry equal to the incoming word
  always_comb begin
    match_mask = {DW{1'b0}};
    any_match  = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (char_vec[i] == mosi) begin
        match_mask = match_mask | mask_vec[i];
        any_match  = 1'b1;
      end else begin
        match_mask = match_mask;
        any_match  = any_match;
      end
    end
  end

endmodule

// File: rtl/spi_match_engine.sv
// SPI-style register-mapped character match engine: char/mask table,
// sticky result register and a streaming compare mode.
module spi_match_engine
  import spi_match_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ENTRIES = 8
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [DW-1:0] mosi,
  output logic [DW-1:0] miso,
  output logic          hit
);

  localparam int PW = $clog2(2 * ENTRIES) + 1;
  localparam int IW = $clog2(ENTRIES);
  localparam logic [PW-1:0] MASK_BASE = PW'(ENTRIES);
  localparam logic [PW-1:0] RES_ADDR  = PW'(2 * ENTRIES);
  localparam logic [DW-1:0] OP_W = DW'(OP_WRITE);
  localparam logic [DW-1:0] OP_R = DW'(OP_READ);
  localparam logic [DW-1:0] OP_C = DW'(OP_CLEAR);
  localparam logic [DW-1:0] OP_S = DW'(OP_STREAM);

  state_t                     state_r, state_nx_s;
  logic [PW-1:0]              ptr_r, mosi_addr_s, ptr_inc_s, addr_inc_s, rd_addr_s;
  logic [DW-1:0]              miso_r, result_r, rd_data_s, match_mask_s;
  logic                       hit_r, any_match_s;
  logic [ENTRIES-1:0][DW-1:0] char_r, mask_r;

  // Pointer increments wrap to 0 from the result address or anything above it
  assign mosi_addr_s = mosi[PW-1:0];
  assign ptr_inc_s   = (ptr_r >= RES_ADDR) ? {PW{1'b0}} : ptr_r + PW'(1);
  assign addr_inc_s  = (mosi_addr_s >= RES_ADDR) ? {PW{1'b0}} : mosi_addr_s + PW'(1);
  assign rd_addr_s   = (state_r == READ_ADDR) ? mosi_addr_s : ptr_r;
  assign miso        = miso_r;
  assign hit         = hit_r;

  // Read mux over the linear map; addresses past result read back zero
  always_comb begin
    rd_data_s = {DW{1'b0}};
    if (rd_addr_s < MASK_BASE) begin
      rd_data_s = char_r[rd_addr_s[IW-1:0]];
    end else if (rd_addr_s < RES_ADDR) begin
      rd_data_s = mask_r[rd_addr_s[IW-1:0]];
    end else if (rd_addr_s == RES_ADDR) begin
      rd_data_s = result_r;
    end else begin
      rd_data_s = {DW{1'b0}};
    end
  end

  spi_match_cam #(.DW(DW), .ENTRIES(ENTRIES)) u_cam (
    .char_vec   (char_r),
    .mask_vec   (mask_r),
    .mosi       (mosi),
    .match_mask (match_mask_s),
    .any_match  (any_match_s)
  );

  // FSM state register
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state decode; cs low always returns to IDLE
  always_comb begin
    state_nx_s = state_r;
    if (!cs) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (mosi == OP_R)      state_nx_s = READ_ADDR;
          else if (mosi == OP_W) state_nx_s = WRITE_ADDR;
          else if (mosi == OP_S) state_nx_s = STREAM;
          else                   state_nx_s = IDLE;
        end
        READ_ADDR:  state_nx_s = READ_BURST;
        READ_BURST: state_nx_s = READ_BURST;
        WRITE_ADDR: state_nx_s = WRITE_DATA;
        WRITE_DATA: state_nx_s = WRITE_DATA;
        STREAM:     state_nx_s = STREAM;
        default:    state_nx_s = IDLE;
      endcase
    end
  end

  // Map writes, pointer, read data, result accumulation and hit pulse
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r    <= {PW{1'b0}};
      miso_r   <= {DW{1'b0}};
      hit_r    <= 1'b0;
      result_r <= {DW{1'b0}};
      char_r   <= '0;
      mask_r   <= '0;
    end else begin
      hit_r <= 1'b0;
      if (cs) begin
        case (state_r)
          IDLE: begin
            if (mosi == OP_C) result_r <= {DW{1'b0}};
          end
          READ_ADDR: begin
            miso_r <= rd_data_s;
            ptr_r  <= addr_inc_s;
          end
          READ_BURST: begin
            miso_r <= rd_data_s;
            ptr_r  <= ptr_inc_s;
          end
          WRITE_ADDR: begin
            ptr_r <= mosi_addr_s;
          end
          WRITE_DATA: begin
            if (ptr_r < MASK_BASE)     char_r[ptr_r[IW-1:0]] <= mosi;
            else if (ptr_r < RES_ADDR) mask_r[ptr_r[IW-1:0]] <= mosi;
            else if (ptr_r == RES_ADDR) result_r <= mosi;
            ptr_r <= ptr_inc_s;
          end
          STREAM: begin
            miso_r   <= result_r;
            result_r <= result_r | match_mask_s;
            hit_r    <= any_match_s;
          end
          default: begin
            hit_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_match_engine.sv
// Directed vector table, reset/abort sequences and a randomized run against a
// word-indexed transaction model of the match engine.
module tb_spi_match_engine;

  typedef struct packed {
    logic       cs;
    logic [7:0] mosi;
    logic [7:0] miso;
    logic       hit;
  } vec_t;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0;
  logic [7:0] mosi = 8'h00;
  logic [7:0] miso;
  logic       hit;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  // model state: map[0..16], word index within transaction, opcode, pointer
  logic [7:0] mm [0:16];
  int         mk;
  logic [7:0] mop;
  int         mp;
  logic [7:0] m_miso;
  logic       m_hit;

  always #5 sclk = ~sclk;

  spi_match_engine #(.DW(8), .ENTRIES(8)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .cs    (cs),
    .mosi  (mosi),
    .miso  (miso),
    .hit   (hit)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic c, input logic [7:0] d);
    @(negedge sclk);
    cs = c;
    mosi = d;
    @(posedge sclk);
    #1;
  endtask

  task automatic v(input logic c, input logic [7:0] d, input logic [7:0] m, input logic h);
    tbl.push_back('{c, d, m, h});
  endtask

  function automatic int m_inc(input int a);
    return (a >= 16) ? 0 : a + 1;
  endfunction

  function automatic logic [7:0] m_rd(input int a);
    return (a <= 16) ? mm[a] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= 16; i++) mm[i] = 8'h00;
    mk = 0; mop = 8'h00; mp = 0; m_miso = 8'h00; m_hit = 1'b0;
  endtask

  task automatic model_edge(input logic c, input logic [7:0] d);
    logic [7:0] msk;
    logic       any;
    m_hit = 1'b0;
    if (!c) begin
      mk = 0;
    end else if (mk == 0) begin
      if (d == 8'h04) mm[16] = 8'h00;
      if (d == 8'h02 || d == 8'h03 || d == 8'h80) begin
        mop = d;
        mk = 1;
      end
    end else begin
      if (mop == 8'h03) begin
        if (mk == 1) mp = int'(d[4:0]);
        m_miso = m_rd(mp);
        mp = m_inc(mp);
      end else if (mop == 8'h02) begin
        if (mk == 1) mp = int'(d[4:0]);
        else begin
          if (mp <= 16) mm[mp] = d;
          mp = m_inc(mp);
        end
      end else begin
        msk = 8'h00;
        any = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (mm[i] == d) begin
            msk = msk | mm[8 + i];
            any = 1'b1;
          end
        end
        m_miso = mm[16];
        mm[16] = mm[16] | msk;
        m_hit = any;
      end
      mk++;
    end
  endtask

  task automatic rstep(input logic c, input logic [7:0] d);
    model_edge(c, d);
    apply(c, d);
    chk("rand_miso", miso, m_miso);
    chk("rand_hit", {7'b0, hit}, {7'b0, m_hit});
  endtask

  task automatic random_run();
    int         sel;
    int         len;
    logic [7:0] opc;
    logic [7:0] d;
    for (int t = 0; t < 250; t++) begin
      sel = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 6));
      if (sel < 3)      opc = 8'h02;
      else if (sel < 6) opc = 8'h03;
      else if (sel < 9) opc = 8'h80;
      else if ($urandom_range(0, 1) == 0) opc = 8'h04;
      else              opc = 8'($urandom_range(0, 255));
      rstep(1'b1, opc);
      for (int j = 0; j < len; j++) begin
        d = 8'($urandom_range(0, 255));
        if (opc == 8'h80 && $urandom_range(0, 1) == 1) d = mm[$urandom_range(0, 7)];
        if ((opc == 8'h02 || opc == 8'h03) && j == 0 && $urandom_range(0, 1) == 1)
          d = 8'($urandom_range(0, 20));
        rstep(1'b1, d);
      end
      rstep(1'b0, 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    // burst write 'a','b' then read back
    v(1, 8'h02, 8'h00, 0); v(1, 8'h00, 8'h00, 0); v(1, 8'h61, 8'h00, 0); v(1, 8'h62, 8'h00, 0);
    v(0, 8'h00, 8'h00, 0);
    v(1, 8'h03, 8'h00, 0); v(1, 8'h00, 8'h61, 0); v(1, 8'h00, 8'h62, 0); v(0, 8'h00, 8'h62, 0);
    // chars 0..3 = 41,10,20,41 ; masks 0..3 = 01,00,00,80
    v(1, 8'h02, 8'h62, 0); v(1, 8'h00, 8'h62, 0); v(1, 8'h41, 8'h62, 0); v(1, 8'h10, 8'h62, 0);
    v(1, 8'h20, 8'h62, 0); v(1, 8'h41, 8'h62, 0); v(0, 8'h00, 8'h62, 0);
    v(1, 8'h02, 8'h62, 0); v(1, 8'h08, 8'h62, 0); v(1, 8'h01, 8'h62, 0); v(1, 8'h00, 8'h62, 0);
    v(1, 8'h00, 8'h62, 0); v(1, 8'h80, 8'h62, 0); v(0, 8'h00, 8'h62, 0);
    // stream with two matching entries
    v(1, 8'h80, 8'h62, 0); v(1, 8'h41, 8'h00, 1); v(1, 8'h55, 8'h81, 0); v(0, 8'h00, 8'h81, 0);
    // read result at 16, wrap to char0
    v(1, 8'h03, 8'h81, 0); v(1, 8'h10, 8'h81, 0); v(1, 8'h00, 8'h41, 0); v(1, 8'h00, 8'h10, 0);
    v(0, 8'h00, 8'h10, 0);
    // clear then illegal opcode, then stream shows cleared result
    v(1, 8'h04, 8'h10, 0); v(1, 8'hFF, 8'h10, 0); v(1, 8'h80, 8'h10, 0); v(1, 8'h55, 8'h00, 0);
    v(0, 8'h00, 8'h00, 0);
    // cs abort after address, then 0x77 as illegal opcode, read char5
    v(1, 8'h02, 8'h00, 0); v(1, 8'h05, 8'h00, 0); v(0, 8'h00, 8'h00, 0); v(1, 8'h77, 8'h00, 0);
    v(1, 8'h03, 8'h00, 0); v(1, 8'h05, 8'h00, 0); v(0, 8'h00, 8'h00, 0);
    // write past result is dropped, pointer wraps to char0
    v(1, 8'h02, 8'h00, 0); v(1, 8'h11, 8'h00, 0); v(1, 8'h99, 8'h00, 0); v(1, 8'h5A, 8'h00, 0);
    v(0, 8'h00, 8'h00, 0);
    v(1, 8'h03, 8'h00, 0); v(1, 8'h11, 8'h00, 0); v(1, 8'h00, 8'h5A, 0); v(1, 8'h00, 8'h10, 0);
    v(0, 8'h00, 8'h10, 0);
    // burst write overwrites result directly
    v(1, 8'h02, 8'h10, 0); v(1, 8'h10, 8'h10, 0); v(1, 8'h33, 8'h10, 0); v(0, 8'h00, 8'h10, 0);
    v(1, 8'h03, 8'h10, 0); v(1, 8'h10, 8'h33, 0); v(0, 8'h00, 8'h33, 0);

    #12;
    chk("reset_miso", miso, 8'h00);
    chk("reset_hit", {7'b0, hit}, 8'h00);
    @(negedge sclk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].cs, tbl[i].mosi);
      chk($sformatf("vec%0d_miso", i), miso, tbl[i].miso);
      chk($sformatf("vec%0d_hit", i), {7'b0, hit}, {7'b0, tbl[i].hit});
    end

    // async reset mid-stream: result=0x77, stream 0x5A matches char0 (mask 0x01)
    apply(1, 8'h02); apply(1, 8'h10); apply(1, 8'h77); apply(0, 8'h00);
    apply(1, 8'h80); apply(1, 8'h5A);
    chk("pre_rst_miso", miso, 8'h77);
    chk("pre_rst_hit", {7'b0, hit}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_miso", miso, 8'h00);
    chk("async_rst_hit", {7'b0, hit}, 8'h00);
    @(negedge sclk);
    rst_n = 1'b1;
    mosi = 8'h03;
    @(posedge sclk);
    #1;
    apply(1, 8'h10);
    chk("post_rst_result", miso, 8'h00);
    chk("post_rst_hit0", {7'b0, hit}, 8'h00);
    apply(1, 8'h00);
    chk("post_rst_char0", miso, 8'h00);
    chk("post_rst_hit1", {7'b0, hit}, 8'h00);
    apply(0, 8'h00);

    // randomized run from a fresh reset
    @(negedge sclk);
    cs = 1'b0;
    rst_n = 1'b0;
    @(negedge sclk);
    rst_n = 1'b1;
    model_reset();
    random_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
